// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch path.
// Holds default sizes, controller mode encodings and the fetch tag layout.
package operand_fetch_unit_pkg;

    localparam int N_DEFAULT          = 5;
    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int ADDR_WIDTH_DEFAULT = 11;

    // Wide enough for kernels up to 16x16; the top zero-extends its slot index.
    localparam int TAG_LOC_W = 8;

    typedef enum logic {
        MODE_IMAGE  = 1'b0,
        MODE_WEIGHT = 1'b1
    } ctrl_mode_e;

    typedef struct packed {
        logic                 valid;
        ctrl_mode_e           mode;
        logic [TAG_LOC_W-1:0] loc;
    } fetch_tag_t;

endpackage

// File: rtl/operand_fetch_unit_tag_pipe.sv
// Delay line that carries each fetch tag alongside its RAM read.
// A kill clears every valid bit so in-flight returns are dropped.
module fetch_tag_pipe
    import operand_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kill,
    input  fetch_tag_t tag_in,
    output fetch_tag_t tag_out
);

    fetch_tag_t stage [DEPTH];

    // Shift tags one stage per cycle; kill invalidates all stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i].valid <= 1'b0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/operand_fetch_unit.sv
// Operand fetch responder: issues RAM reads for controller requests and
// steers returned bytes into the weight bank or the sliding pixel window.
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
    parameter int N           = N_DEFAULT,
    parameter int RAM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ctrl_ram_en,
    input  logic                         ctrl_write_en,
    input  logic                         ctrl_WorI,
    input  logic [ADDR_WIDTH-1:0]        ctrl_read_addr,
    input  logic [$clog2(N*N)-1:0]       ctrl_weight_location,
    input  logic                         flush,
    output logic                         ram_en,
    output logic [ADDR_WIDTH-1:0]        ram_addr,
    input  logic [DATA_WIDTH-1:0]        ram_rdata,
    output logic [N*N*DATA_WIDTH-1:0]    weights_flat,
    output logic [N*N*DATA_WIDTH-1:0]    window_flat,
    output logic                         weights_ready,
    output logic                         window_valid,
    output logic                         loc_err
);

    localparam int NN = N * N;
    localparam int LW = $clog2(NN);
    localparam int CW = $clog2(NN + 1);

    logic                  accept;
    ctrl_mode_e            iss_mode;
    logic [LW-1:0]         iss_loc;
    fetch_tag_t            tag_in;
    fetch_tag_t            tag_out;
    logic                  ret_hit;
    logic                  wr_weight;
    logic                  wr_image;
    logic [DATA_WIDTH-1:0] bank   [NN];
    logic [DATA_WIDTH-1:0] window [NN];
    logic [NN-1:0]         mask;
    logic [CW-1:0]         pix_cnt;

    assign accept = ctrl_ram_en & ~ctrl_write_en & ~flush;

    // Register an accepted request onto the RAM port for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en   <= 1'b0;
            ram_addr <= '0;
            iss_mode <= MODE_IMAGE;
            iss_loc  <= '0;
        end else begin
            ram_en <= accept;
            if (accept) begin
                ram_addr <= ctrl_read_addr;
                iss_mode <= ctrl_mode_e'(ctrl_WorI);
                iss_loc  <= ctrl_weight_location;
            end
        end
    end

    // Build the tag for the read currently on the RAM port.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = ram_en;
        tag_in.mode  = iss_mode;
        tag_in.loc   = TAG_LOC_W'(iss_loc);
    end

    fetch_tag_pipe #(
        .DEPTH (RAM_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .kill    (flush),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign ret_hit   = tag_out.valid & ~flush;
    assign wr_weight = ret_hit
                     & (tag_out.mode == MODE_WEIGHT)
                     & (int'(tag_out.loc) < NN);
    assign wr_image  = ret_hit & (tag_out.mode == MODE_IMAGE);

    // Flag weight requests that name a slot outside the bank; sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loc_err <= 1'b0;
        end else if (accept && ctrl_WorI
                     && int'(ctrl_weight_location) >= NN) begin
            loc_err <= 1'b1;
        end
    end

    // Store weight returns by slot; flush clears only the written mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NN; k++) begin
                bank[k] <= '0;
            end
            mask <= '0;
        end else begin
            if (wr_weight) begin
                for (int k = 0; k < NN; k++) begin
                    if (int'(tag_out.loc) == k) begin
                        bank[k] <= ram_rdata;
                        mask[k] <= 1'b1;
                    end
                end
            end
            if (flush) begin
                mask <= '0;
            end
        end
    end

    // Shift pixel returns into the window and count up to a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NN; k++) begin
                window[k] <= '0;
            end
            pix_cnt <= '0;
        end else if (flush) begin
            for (int k = 0; k < NN; k++) begin
                window[k] <= '0;
            end
            pix_cnt <= '0;
        end else if (wr_image) begin
            window[0] <= ram_rdata;
            for (int k = 1; k < NN; k++) begin
                window[k] <= window[k-1];
            end
            if (pix_cnt != CW'(NN)) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

    // Flatten bank and window for the PE array.
    always_comb begin
        weights_flat = '0;
        window_flat  = '0;
        for (int k = 0; k < NN; k++) begin
            weights_flat[k*DATA_WIDTH +: DATA_WIDTH] = bank[k];
            window_flat[k*DATA_WIDTH +: DATA_WIDTH]  = window[k];
        end
    end

    assign weights_ready = &mask;
    assign window_valid  = (pix_cnt == CW'(NN));

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: two instances (RAM latency 1 and 3)
// share stimulus; a RAM model per instance returns addr[7:0]^8'h5A.
module tb_operand_fetch_unit;

    localparam int N  = 5;
    localparam int NN = N * N;
    localparam int DW = 8;
    localparam int AW = 11;
    localparam int LW = $clog2(NN);
    localparam int FW = NN * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          wen = 1'b0;
    logic          wori = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [LW-1:0] loc = '0;
    logic          flush = 1'b0;

    logic          ram_en1, ram_en3;
    logic [AW-1:0] ram_addr1, ram_addr3;
    logic [DW-1:0] rdata1, rdata3;
    logic [FW-1:0] wf1, wf3, win1, win3;
    logic          wr1, wr3, wv1, wv3, le1, le3;

    int checks = 0;
    int failures = 0;
    int iss1 = 0;
    int iss3 = 0;
    logic [AW-1:0] q1 [$];
    logic [AW-1:0] q3 [$];

    always #5 clk = ~clk;

    operand_fetch_unit #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .N (N), .RAM_LATENCY (1)
    ) dut1 (
        .clk (clk), .rst_n (rst_n),
        .ctrl_ram_en (req), .ctrl_write_en (wen), .ctrl_WorI (wori),
        .ctrl_read_addr (addr), .ctrl_weight_location (loc), .flush (flush),
        .ram_en (ram_en1), .ram_addr (ram_addr1), .ram_rdata (rdata1),
        .weights_flat (wf1), .window_flat (win1),
        .weights_ready (wr1), .window_valid (wv1), .loc_err (le1)
    );

    operand_fetch_unit #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .N (N), .RAM_LATENCY (3)
    ) dut3 (
        .clk (clk), .rst_n (rst_n),
        .ctrl_ram_en (req), .ctrl_write_en (wen), .ctrl_WorI (wori),
        .ctrl_read_addr (addr), .ctrl_weight_location (loc), .flush (flush),
        .ram_en (ram_en3), .ram_addr (ram_addr3), .ram_rdata (rdata3),
        .weights_flat (wf3), .window_flat (win3),
        .weights_ready (wr3), .window_valid (wv3), .loc_err (le3)
    );

    // RAM models: address sampled on the edge after ram_en, data LAT edges later.
    logic [AW-1:0] m1;
    logic [AW-1:0] m3 [3];
    always @(posedge clk) begin
        m1    <= ram_addr1;
        m3[0] <= ram_addr3;
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign rdata1 = m1[7:0] ^ 8'h5A;
    assign rdata3 = m3[2][7:0] ^ 8'h5A;

    // Issue-port scoreboards: every ram_en cycle must match the oldest expected address.
    always @(negedge clk) begin
        if (rst_n && ram_en1) begin
            iss1++;
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL issue1_unexpected got_addr=%0d required=no_issue", ram_addr1);
            end else if (ram_addr1 !== q1[0]) begin
                failures++;
                $display("FAIL issue1_addr got=%0d required=%0d", ram_addr1, q1[0]);
                void'(q1.pop_front());
            end else begin
                void'(q1.pop_front());
            end
        end
        if (rst_n && ram_en3) begin
            iss3++;
            checks++;
            if (q3.size() == 0) begin
                failures++;
                $display("FAIL issue3_unexpected got_addr=%0d required=no_issue", ram_addr3);
            end else if (ram_addr3 !== q3[0]) begin
                failures++;
                $display("FAIL issue3_addr got=%0d required=%0d", ram_addr3, q3[0]);
                void'(q3.pop_front());
            end else begin
                void'(q3.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input bit w, input int a, input int l);
        req  = 1'b1;
        wen  = 1'b0;
        wori = w;
        addr = AW'(a);
        loc  = LW'(l);
        if (!flush && rst_n) begin
            q1.push_back(AW'(a));
            q3.push_back(AW'(a));
        end
        tick();
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        wen = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({ram_en1, ram_addr1, wr1, wv1, le1, ram_en3, ram_addr3, wr3, wv3, le3} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%h required=0",
                     {ram_en1, ram_addr1, wr1, wv1, le1, ram_en3, ram_addr3, wr3, wv3, le3});
        end
        checks++;
        if ({wf1, win1, wf3, win3} !== '0) begin
            failures++;
            $display("FAIL reset_data got_nonzero=%0d required=0", ({wf1, win1, wf3, win3} != '0));
        end
        rst_n = 1'b1;
        tick();
        request(0, 60, 0);
        request(0, 61, 0);
        request(0, 62, 0);
        checks++;
        if (win1[7:0] !== 8'h66) begin
            failures++;
            $display("FAIL burst_first_pixel got=%h required=66", win1[7:0]);
        end
        #1 rst_n = 1'b0;
        req = 1'b0;
        #1;
        q1.delete();
        q3.delete();
        checks++;
        if ({ram_en1, ram_en3, win1, win3, wv1, wv3} !== '0) begin
            failures++;
            $display("FAIL midburst_reset en1=%b en3=%b win1_nz=%0d win3_nz=%0d",
                     ram_en1, ram_en3, win1 != '0, win3 != '0);
        end
        tick();
        rst_n = 1'b1;
        iss1 = 0;
        iss3 = 0;
        idle(6);
        checks++;
        if (iss1 != 0 || iss3 != 0 || ram_en1 || ram_en3 || win1 != '0 || win3 != '0) begin
            failures++;
            $display("FAIL post_reset_quiet iss1=%0d iss3=%0d required=0 0", iss1, iss3);
        end
    endtask

    task automatic test_weight_preload();
        int rise1 = -1;
        int rise3 = -1;
        logic [FW-1:0] exp_w;
        iss1 = 0;
        iss3 = 0;
        for (int l = 0; l < NN; l++) request(1, 100 + l, l);
        req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rise1 < 0 && wr1) rise1 = k;
            if (rise3 < 0 && wr3) rise3 = k;
        end
        checks++;
        if (rise1 != 2 || rise3 != 4) begin
            failures++;
            $display("FAIL weights_ready_timing got=%0d,%0d required=2,4", rise1, rise3);
        end
        checks++;
        if (iss1 != NN || iss3 != NN || q1.size() != 0 || q3.size() != 0) begin
            failures++;
            $display("FAIL preload_issue_count got=%0d,%0d required=%0d", iss1, iss3, NN);
        end
        checks++;
        if (wf1[7*DW +: DW] !== 8'h31) begin
            failures++;
            $display("FAIL slot7 got=%h required=31", wf1[7*DW +: DW]);
        end
        exp_w = '0;
        for (int k = 0; k < NN; k++) exp_w[k*DW +: DW] = 8'(100 + k) ^ 8'h5A;
        checks++;
        if (wf1 !== exp_w || wf3 !== exp_w) begin
            failures++;
            $display("FAIL weight_bank got1=%h got3=%h required=%h", wf1, wf3, exp_w);
        end
    endtask

    task automatic test_image_stream();
        int rise1 = -1;
        int rise3 = -1;
        logic [FW-1:0] exp_p;
        iss1 = 0;
        iss3 = 0;
        for (int i = 0; i < 30; i++) begin
            request(0, i, 0);
            if (rise1 < 0 && wv1) rise1 = i;
            if (rise3 < 0 && wv3) rise3 = i;
        end
        req = 1'b0;
        for (int k = 30; k < 38; k++) begin
            tick();
            if (rise1 < 0 && wv1) rise1 = k;
            if (rise3 < 0 && wv3) rise3 = k;
        end
        checks++;
        if (rise1 != 26 || rise3 != 28) begin
            failures++;
            $display("FAIL window_valid_timing got=%0d,%0d required=26,28", rise1, rise3);
        end
        checks++;
        if (win1[7:0] !== 8'h47 || win1[24*DW +: DW] !== 8'h5F) begin
            failures++;
            $display("FAIL window_ends got=%h,%h required=47,5f", win1[7:0], win1[24*DW +: DW]);
        end
        exp_p = '0;
        for (int k = 0; k < NN; k++) exp_p[k*DW +: DW] = 8'(29 - k) ^ 8'h5A;
        checks++;
        if (win1 !== exp_p || win3 !== exp_p) begin
            failures++;
            $display("FAIL window_contents got1=%h got3=%h required=%h", win1, win3, exp_p);
        end
        checks++;
        if (wv1 !== 1'b1 || wv3 !== 1'b1 || iss1 != 30 || iss3 != 30) begin
            failures++;
            $display("FAIL stream_saturate wv=%b%b iss=%0d,%0d required=11 30,30", wv1, wv3, iss1, iss3);
        end
    endtask

    task automatic test_bad_slot();
        logic [FW-1:0] s1 = wf1;
        logic [FW-1:0] s3 = wf3;
        iss1 = 0;
        iss3 = 0;
        request(1, 200, 27);
        checks++;
        if (le1 !== 1'b1 || le3 !== 1'b1) begin
            failures++;
            $display("FAIL loc_err_set got=%b%b required=11", le1, le3);
        end
        idle(6);
        checks++;
        if (wf1 !== s1 || wf3 !== s3 || wr1 !== 1'b1 || iss1 != 1 || iss3 != 1) begin
            failures++;
            $display("FAIL bad_slot_discard bank_changed=%0d,%0d ready=%b iss=%0d,%0d required=0,0 1 1,1",
                     wf1 != s1, wf3 != s3, wr1, iss1, iss3);
        end
    endtask

    task automatic test_flush_in_flight();
        logic [FW-1:0] s1 = wf1;
        logic [FW-1:0] s3 = wf3;
        iss1 = 0;
        iss3 = 0;
        request(0, 40, 0);
        request(0, 41, 0);
        request(0, 42, 0);
        req   = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (win1 !== '0 || wv1 !== 1'b0 || wr1 !== 1'b0 || wf1 !== s1 || le1 !== 1'b1) begin
            failures++;
            $display("FAIL flush_edge win_nz=%0d wv=%b wr=%b bank_changed=%0d le=%b required=0 0 0 0 1",
                     win1 != '0, wv1, wr1, wf1 != s1, le1);
        end
        idle(6);
        checks++;
        if (win1 !== '0 || win3 !== '0 || wv3 !== 1'b0 || wr3 !== 1'b0) begin
            failures++;
            $display("FAIL flush_discard win1=%h win3=%h required=0", win1[23:0], win3[23:0]);
        end
        checks++;
        if (wf3 !== s3 || le3 !== 1'b1 || iss1 != 3 || iss3 != 3) begin
            failures++;
            $display("FAIL flush_retain bank_changed=%0d le=%b iss=%0d,%0d required=0 1 3,3",
                     wf3 != s3, le3, iss1, iss3);
        end
    endtask

    task automatic test_rewrite();
        request(1, 250, 0);
        request(1, 251, 0);
        idle(6);
        checks++;
        if (wf1[7:0] !== 8'hA1 || wf3[7:0] !== 8'hA1 || wr1 !== 1'b0 || wr3 !== 1'b0) begin
            failures++;
            $display("FAIL slot_rewrite got=%h,%h ready=%b%b required=a1,a1 00",
                     wf1[7:0], wf3[7:0], wr1, wr3);
        end
    endtask

    task automatic test_write_gating();
        logic [2*FW+2:0] s1 = {wf1, win1, wr1, wv1, le1};
        logic [2*FW+2:0] s3 = {wf3, win3, wr3, wv3, le3};
        iss1 = 0;
        iss3 = 0;
        req  = 1'b1;
        wen  = 1'b1;
        wori = 1'b0;
        addr = AW'(77);
        for (int i = 0; i < 4; i++) tick();
        idle(5);
        checks++;
        if (iss1 != 0 || iss3 != 0) begin
            failures++;
            $display("FAIL write_gating_issue got=%0d,%0d required=0,0", iss1, iss3);
        end
        checks++;
        if ({wf1, win1, wr1, wv1, le1} !== s1 || {wf3, win3, wr3, wv3, le3} !== s3) begin
            failures++;
            $display("FAIL write_gating_state changed=%0d,%0d required=0,0",
                     {wf1, win1, wr1, wv1, le1} != s1, {wf3, win3, wr3, wv3, le3} != s3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time_limit_reached required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_weight_preload();
        test_image_stream();
        test_bad_slot();
        test_flush_in_flight();
        test_rewrite();
        test_write_gating();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
